vend_motor_arbiter: RTL and testbench
=====================================

VEND_MOTOR_ARBITER -- requirements
Module: vend_motor_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of vending stations sharing one dispense motor.
REQ-002 The block SHALL have parameter RUN_CYCLES, default 8: motor-on cycles per dispense.
REQ-003 The block SHALL have parameter TIMEOUT, default 32: post-run cycles allowed for drop_sense before a fault is declared.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, N_REQ bits: per-station dispense request, sampled every clock.
REQ-007 The block SHALL have port req_product, input, 2*N_REQ bits: 2-bit product code per station; bits [2i+1:2i] belong to station i.
REQ-008 The block SHALL have port drop_sense, input, 1 bit: chute sensor, high when a product has fallen.
REQ-009 The block SHALL have port clear_fault, input, 1 bit: operator fault acknowledge.
REQ-010 The block SHALL have port motor, output, 1 bit: dispense motor enable.
REQ-011 The block SHALL have port motor_sel, output, 2 bits: granted station index.
REQ-012 The block SHALL have port motor_product, output, 2 bits: product code being dispensed.
REQ-013 The block SHALL have port done, output, N_REQ bits: one-cycle completion pulse to the granted station.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 The block SHALL have port fault, output, 1 bit: jam fault flag.
REQ-016 The block SHALL have port LED, output, 3 bits: status code; 001 idle, 010 dispensing, 100 fault.

Function
REQ-017 A high req[i] SHALL set pending[i] and capture station i's product code, unless station i is already pending or in service, in which case the request SHALL be ignored.
REQ-018 The FSM SHALL use the states IDLE, GRANT, RUN, WAIT_SENSE, DONE and FAULT.
REQ-019 In IDLE with any pending bit set, the FSM SHALL pick one station round-robin, starting after last_grant (last_grant = N_REQ-1 after reset), and move to GRANT.
REQ-020 On the GRANT transition, the FSM SHALL register motor_sel and motor_product and clear the winner's pending bit.
REQ-021 GRANT SHALL last one cycle and then move to RUN.
REQ-022 RUN SHALL hold motor=1 for exactly RUN_CYCLES cycles.
REQ-023 Latency: with the FSM in IDLE and req[i] sampled at edge k, motor SHALL be high from edge k+3 (pending at k, GRANT at k+1, RUN at k+2, registered motor at k+3; total 3 edges).
REQ-024 A drop_sense high during RUN SHALL be latched, and at the end of RUN the FSM SHALL go directly to DONE.
REQ-025 If drop_sense was not seen during RUN, the FSM SHALL enter WAIT_SENSE with motor=0.
REQ-026 In WAIT_SENSE, drop_sense high SHALL move the FSM to DONE.
REQ-027 In WAIT_SENSE, TIMEOUT cycles without drop_sense SHALL move the FSM to FAULT.
REQ-028 DONE SHALL pulse done[motor_sel] for one cycle, update last_grant, and return to IDLE.
REQ-029 FAULT SHALL hold fault=1, motor=0 and LED=100, SHALL not pulse done, and SHALL keep pending requests queued.
REQ-030 clear_fault in FAULT SHALL return the FSM to IDLE and advance last_grant past the faulted station.
REQ-031 clear_fault outside FAULT SHALL be ignored.
REQ-032 A req[i] arriving in the same cycle as another station's grant SHALL be queued.
REQ-033 Several simultaneous req bits SHALL all be queued.
REQ-034 The run counter SHALL be sized $clog2(RUN_CYCLES+1) bits and SHALL not wrap.
REQ-035 The timeout counter SHALL be sized $clog2(TIMEOUT+1) bits and SHALL not wrap.

Reset
REQ-036 With reset low, asynchronously: state=IDLE, pending=0, last_grant=N_REQ-1, motor=0, motor_sel=0, motor_product=0, done=0, busy=0, fault=0, LED=001.
REQ-037 Reset asserted mid-dispense SHALL drop motor immediately and discard all queued requests.

Structure
REQ-038 Package vend_pkg SHALL hold the FSM state enum, the LED code constants and the product-code width.
REQ-039 Round-robin selection SHALL be a combinational sub-module vend_rr_arbiter with inputs pending and last_grant and outputs grant_valid and grant_idx.

Verification
REQ-040 Single request: req=0001, product 01, drop_sense at RUN cycle 4 -> motor high for 8 cycles, motor_sel=0, motor_product=01, done=0001 one cycle after RUN ends, LED back to 001.
REQ-041 Contention: req=1011 in one cycle, sensor always succeeds -> service order stations 0,1,3, then a new req=0001 is served after station 3.
REQ-042 Late sensor: drop_sense 10 cycles after RUN ends -> WAIT_SENSE then DONE, no fault.
REQ-043 Jam: no drop_sense -> fault=1 and LED=100 32 cycles after RUN ends, done stays 0; clear_fault -> IDLE, next pending station served.
REQ-044 Duplicate: req[2] pulsed again while station 2 is in RUN -> ignored, exactly one done[2].
REQ-045 Reset: reset low at RUN cycle 3 -> motor=0 in the same cycle, all outputs at reset values, queued req=0100 discarded.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense-motor arbiter.
package vend_pkg;

  // Width of the per-station product code.
  localparam int PROD_W = 2;

  // Status LED codes.
  localparam logic [2:0] LED_IDLE     = 3'b001;
  localparam logic [2:0] LED_DISPENSE = 3'b010;
  localparam logic [2:0] LED_FAULT    = 3'b100;

  // Dispense sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RUN,
    ST_WAIT_SENSE,
    ST_DONE,
    ST_FAULT
  } state_t;

endpackage

// File: rtl/vend_rr_arbiter.sv
// Combinational round-robin picker: the first pending station strictly after
// last_grant, wrapping around, wins.
module vend_rr_arbiter
  import vend_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IDX_W-1:0] last_grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down to the nearest so the nearest pending
  // station after last_grant is the last (winning) assignment.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (pending[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/vend_motor_arbiter.sv
// Shares one dispense motor among N_REQ vending stations: queues requests,
// grants round-robin, runs the motor, waits for the chute sensor and flags
// a jam if the product never drops.
module vend_motor_arbiter
  import vend_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int RUN_CYCLES = 8,
  parameter int TIMEOUT    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [2*N_REQ-1:0]  req_product,
  input  logic                drop_sense,
  input  logic                clear_fault,
  output logic                motor,
  output logic [1:0]          motor_sel,
  output logic [PROD_W-1:0]   motor_product,
  output logic [N_REQ-1:0]    done,
  output logic                busy,
  output logic                fault,
  output logic [2:0]          LED
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RUN_W = $clog2(RUN_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_t              state_reg, state_next;
  logic [N_REQ-1:0]    pending_reg;
  logic [PROD_W-1:0]   product_reg [N_REQ];
  logic [IDX_W-1:0]    last_grant_reg;
  logic [RUN_W-1:0]    run_cnt_reg;
  logic [TO_W-1:0]     to_cnt_reg;
  logic                sensed_reg;
  logic                motor_reg;
  logic [1:0]          sel_reg;
  logic [PROD_W-1:0]   product_out_reg;
  logic [N_REQ-1:0]    done_reg;

  logic                grant_valid;
  logic [IDX_W-1:0]    grant_idx;
  logic                take_grant;
  logic                run_last;
  logic                to_last;

  vend_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .pending     (pending_reg),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign take_grant = (state_reg == ST_IDLE) && grant_valid;
  assign run_last   = (run_cnt_reg == RUN_W'(RUN_CYCLES - 1));
  assign to_last    = (to_cnt_reg == TO_W'(TIMEOUT - 1));

  // Per-station request queue: a station already waiting or being served
  // cannot queue a second dispense.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_station
    logic in_service;
    assign in_service = (state_reg != ST_IDLE) && (sel_reg == 2'(gi));

    // Capture a new request with its product code; drop it when granted.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pending_reg[gi] <= 1'b0;
        product_reg[gi] <= '0;
      end else if (req[gi] && !pending_reg[gi] && !in_service) begin
        pending_reg[gi] <= 1'b1;
        product_reg[gi] <= req_product[2*gi +: PROD_W];
      end else if (take_grant && (grant_idx == IDX_W'(gi))) begin
        pending_reg[gi] <= 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic for the dispense sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:       if (grant_valid) state_next = ST_GRANT;
      ST_GRANT:      state_next = ST_RUN;
      ST_RUN:        if (run_last)
                       state_next = (sensed_reg || drop_sense) ? ST_DONE : ST_WAIT_SENSE;
      ST_WAIT_SENSE: if (drop_sense)   state_next = ST_DONE;
                     else if (to_last) state_next = ST_FAULT;
      ST_DONE:       state_next = ST_IDLE;
      ST_FAULT:      if (clear_fault) state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  // Run/timeout counters and the in-run sensor latch; each holds at its
  // terminal value instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      sensed_reg  <= 1'b0;
    end else begin
      run_cnt_reg <= (state_reg == ST_RUN) ?
                     (run_last ? run_cnt_reg : run_cnt_reg + 1'b1) : '0;
      to_cnt_reg  <= (state_reg == ST_WAIT_SENSE) ?
                     (to_last ? to_cnt_reg : to_cnt_reg + 1'b1) : '0;
      sensed_reg  <= (state_reg == ST_RUN) ? (sensed_reg | drop_sense) : 1'b0;
    end
  end

  // Grant bookkeeping and registered motor/done outputs (one cycle behind state).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_reg  <= IDX_W'(N_REQ - 1);
      sel_reg         <= '0;
      product_out_reg <= '0;
      motor_reg       <= 1'b0;
      done_reg        <= '0;
    end else begin
      if (take_grant) begin
        sel_reg         <= 2'(grant_idx);
        product_out_reg <= product_reg[grant_idx];
      end
      if ((state_reg == ST_DONE) || ((state_reg == ST_FAULT) && clear_fault))
        last_grant_reg <= IDX_W'(sel_reg);
      motor_reg <= (state_reg == ST_RUN);
      done_reg  <= (state_reg == ST_DONE) ? (N_REQ'(1) << sel_reg) : '0;
    end
  end

  // Status LED decoded from the current state.
  always_comb begin
    LED = LED_DISPENSE;
    case (state_reg)
      ST_IDLE:  LED = LED_IDLE;
      ST_FAULT: LED = LED_FAULT;
      default:  LED = LED_DISPENSE;
    endcase
  end

  assign motor         = motor_reg;
  assign motor_sel     = sel_reg;
  assign motor_product = product_out_reg;
  assign done          = done_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign fault         = (state_reg == ST_FAULT);

endmodule

// File: tb/tb_vend_motor_arbiter.sv
// Scoreboard bench for vend_motor_arbiter: directed scenarios push expected
// completions/faults, a monitor pops and compares on each done pulse or fault.
module tb_vend_motor_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [7:0] req_product;
  logic       drop_sense;
  logic       clear_fault;
  logic       motor;
  logic [1:0] motor_sel;
  logic [1:0] motor_product;
  logic [3:0] done;
  logic       busy;
  logic       fault;
  logic [2:0] LED;

  vend_motor_arbiter #(.N_REQ(4), .RUN_CYCLES(8), .TIMEOUT(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_product   (req_product),
    .drop_sense    (drop_sense),
    .clear_fault   (clear_fault),
    .motor         (motor),
    .motor_sel     (motor_sel),
    .motor_product (motor_product),
    .done          (done),
    .busy          (busy),
    .fault         (fault),
    .LED           (LED)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_fault;
    logic [3:0] done_vec;
    logic [1:0] sel;
    logic [1:0] prod;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   sense_mode = 0;   // 0: sense at motor cycle 4, 1: never, 2: 10 cycles after motor stops
  int   n_done2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push_done(input logic [1:0] sel, input logic [1:0] prod);
    exp_t e;
    e.is_fault = 1'b0;
    e.done_vec = 4'b0001 << sel;
    e.sel      = sel;
    e.prod     = prod;
    sb.push_back(e);
  endtask

  task automatic push_fault(input logic [1:0] sel);
    exp_t e;
    e.is_fault = 1'b1;
    e.done_vec = 4'b0000;
    e.sel      = sel;
    e.prod     = 2'b00;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] r, input logic [7:0] p);
    @(negedge clk);
    req = r;
    req_product = p;
    @(posedge clk);
    #1;
    req = 4'b0000;
  endtask

  task automatic wait_motor_sel(input string name, input logic [1:0] sel);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(motor && motor_sel == sel) && n < 500);
    check(name, {motor, motor_sel}, {1'b1, sel});
  endtask

  task automatic wait_motor_low(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (motor && n < 100);
    check(name, motor, 1'b0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    check(name, busy, 1'b0);
  endtask

  // Chute sensor model driven away from the active edge.
  initial begin : sensor
    int mcnt;
    int wcnt;
    mcnt = 0;
    wcnt = 0;
    drop_sense = 1'b0;
    forever begin
      @(negedge clk);
      if (motor) begin
        mcnt++;
        wcnt = 0;
      end else begin
        mcnt = 0;
        wcnt = (busy && !fault) ? wcnt + 1 : 0;
      end
      drop_sense = (sense_mode == 0 && motor && mcnt == 4) ||
                   (sense_mode == 2 && !motor && busy && wcnt == 10);
    end
  end

  // Monitor: pops the scoreboard on every completion pulse and fault entry.
  initial begin : monitor
    int   run_len;
    logic prev_motor;
    logic prev_fault;
    exp_t e;
    run_len = 0;
    prev_motor = 1'b0;
    prev_fault = 1'b0;
    forever begin
      @(negedge clk);
      if (motor && !prev_motor) run_len = 0;
      if (motor) run_len++;
      if (done !== 4'b0000) begin
        if (done[2]) n_done2++;
        if (sb.size() == 0) begin
          check("unexpected_done", {28'd0, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_kind", {31'd0, e.is_fault}, 32'd0);
          check("done_vec", {28'd0, done}, {28'd0, e.done_vec});
          check("done_sel", {30'd0, motor_sel}, {30'd0, e.sel});
          check("done_prod", {30'd0, motor_product}, {30'd0, e.prod});
          check("run_len", run_len, 8);
          $display("done: station %0d product %0d motor cycles %0d", motor_sel, motor_product, run_len);
        end
      end
      if (fault && !prev_fault) begin
        if (sb.size() == 0) begin
          check("unexpected_fault", {31'd0, fault}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("fault_kind", {31'd0, e.is_fault}, 32'd1);
          check("fault_sel", {30'd0, motor_sel}, {30'd0, e.sel});
          $display("fault: station %0d jammed", motor_sel);
        end
      end
      prev_motor = motor;
      prev_fault = fault;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int d2_before;
    reset = 1'b0;
    req = 4'b0000;
    req_product = 8'h00;
    clear_fault = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_motor", motor, 1'b0);
    check("rst_sel", motor_sel, 2'b00);
    check("rst_prod", motor_product, 2'b00);
    check("rst_done", done, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_led", LED, 3'b001);
    @(negedge clk) reset = 1'b1;

    // Single request: latency of three edges, then 8 motor cycles.
    sense_mode = 0;
    push_done(2'd0, 2'b01);
    issue(4'b0001, 8'h01);
    @(posedge clk); #1;
    check("t1_grant_busy", busy, 1'b1);
    check("t1_grant_motor", motor, 1'b0);
    @(posedge clk); #1;
    check("t1_run_motor_pre", motor, 1'b0);
    @(posedge clk); #1;
    check("t1_motor_on", motor, 1'b1);
    check("t1_sel", motor_sel, 2'd0);
    check("t1_prod", motor_product, 2'b01);
    check("t1_led", LED, 3'b010);
    wait_idle("t1_idle");
    check("t1_led_idle", LED, 3'b001);

    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;

    // Contention: 0,1,3 then a late request from 0.
    push_done(2'd0, 2'b10);
    push_done(2'd1, 2'b11);
    push_done(2'd3, 2'b01);
    push_done(2'd0, 2'b00);
    issue(4'b1011, 8'b01_00_11_10);
    wait_motor_sel("t2_reach_st1", 2'd1);
    issue(4'b0001, 8'h00);
    wait_idle("t2_idle");

    // Late sensor: WAIT_SENSE then DONE without fault.
    sense_mode = 2;
    push_done(2'd2, 2'b11);
    issue(4'b0100, 8'h30);
    wait_motor_sel("t3_reach_st2", 2'd2);
    wait_motor_low("t3_motor_low");
    repeat (5) @(negedge clk);
    check("t3_wait_busy", busy, 1'b1);
    check("t3_wait_motor", motor, 1'b0);
    check("t3_wait_fault", fault, 1'b0);
    check("t3_wait_led", LED, 3'b010);
    wait_idle("t3_idle");

    // Jam on station 3, station 1 stays queued and is served after clear.
    sense_mode = 1;
    push_fault(2'd3);
    push_done(2'd1, 2'b10);
    issue(4'b1010, 8'b01_00_10_00);
    wait_motor_sel("t4_reach_st3", 2'd3);
    wait_motor_low("t4_motor_low");
    repeat (30) @(posedge clk);
    #1;
    check("t4_fault_early", fault, 1'b0);
    @(posedge clk); #1;
    check("t4_fault", fault, 1'b1);
    check("t4_led", LED, 3'b100);
    check("t4_motor", motor, 1'b0);
    check("t4_done", done, 4'b0000);
    sense_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    check("t4_fault_held", fault, 1'b1);
    @(negedge clk) clear_fault = 1'b1;
    @(negedge clk) clear_fault = 1'b0;
    check("t4_cleared", fault, 1'b0);
    wait_motor_sel("t4_reach_st1", 2'd1);
    @(negedge clk) clear_fault = 1'b1;
    @(negedge clk) clear_fault = 1'b0;
    check("t4_stray_clear", {motor, fault}, 2'b10);
    wait_idle("t4_idle");

    // Duplicate request while station 2 runs.
    d2_before = n_done2;
    push_done(2'd2, 2'b01);
    issue(4'b0100, 8'h10);
    wait_motor_sel("t5_reach_st2", 2'd2);
    issue(4'b0100, 8'h30);
    wait_idle("t5_idle");
    repeat (20) @(posedge clk);
    check("t5_one_done", n_done2 - d2_before, 1);
    check("t5_sb_empty", sb.size(), 0);

    // Reset mid-run discards the queue.
    issue(4'b0001, 8'h03);
    wait_motor_sel("t6_reach_st0", 2'd0);
    issue(4'b0100, 8'h20);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_motor", motor, 1'b0);
    check("t6_sel", motor_sel, 2'd0);
    check("t6_prod", motor_product, 2'b00);
    check("t6_done", done, 4'b0000);
    check("t6_busy", busy, 1'b0);
    check("t6_fault", fault, 1'b0);
    check("t6_led", LED, 3'b001);
    @(negedge clk) reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("t6_queue_dropped", {busy, motor}, 2'b00);
    check("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
